// File: rtl/fsmc_pkg.sv
// ============================================================================
//  Module   : fsmc_pkg
//  Purpose  : Shared types and constants for the FSMC slave bridge.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fsmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_ACT = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_RD_CAP = 3'd3,
        ST_RD_DRV = 3'd4
    } fsmc_state_t;

    localparam int unsigned C_SYNC_STAGES_DEFAULT = 2;

    // {ne, noe, nwe} with every strobe deasserted
    localparam logic [2:0]  C_BUS_IDLE = 3'b111;

endpackage

`default_nettype wire

// File: rtl/fsmc_slave_if_if.sv
// ============================================================================
//  Module   : fsmc_bus_if
//  Purpose  : FSMC pin-side bus bundle; fsmc_nwait exists only when
//             FSMC_NWAIT_EN is defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fsmc_bus_if #(
    parameter int unsigned p_WIDTH_ADDR = 16,
    parameter int unsigned p_WIDTH_DATA = 16
);
    logic                    fsmc_ne;
    logic                    fsmc_noe;
    logic                    fsmc_nwe;
    logic [p_WIDTH_ADDR-1:0] fsmc_a;
    logic [p_WIDTH_DATA-1:0] fsmc_d_i;
    logic [p_WIDTH_DATA-1:0] fsmc_d_o;
    logic                    fsmc_d_oe;
`ifdef FSMC_NWAIT_EN
    logic                    fsmc_nwait;

    modport master (
        output fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_a, fsmc_d_i,
        input  fsmc_d_o, fsmc_d_oe, fsmc_nwait
    );
    modport slave (
        input  fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_a, fsmc_d_i,
        output fsmc_d_o, fsmc_d_oe, fsmc_nwait
    );
`else
    modport master (
        output fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_a, fsmc_d_i,
        input  fsmc_d_o, fsmc_d_oe
    );
    modport slave (
        input  fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_a, fsmc_d_i,
        output fsmc_d_o, fsmc_d_oe
    );
`endif
endinterface

`default_nettype wire

// File: rtl/fsmc_slave_if_sync_bits.sv
// ============================================================================
//  Module   : sync_bits
//  Purpose  : 3-bit multi-stage synchroniser, preset to the idle bus level.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_bits
    import fsmc_pkg::*;
#(
    parameter int unsigned p_STAGES = C_SYNC_STAGES_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [2:0] d,
    output logic      [2:0] q
);

    logic [p_STAGES-1:0][2:0] stage_q;
    logic [p_STAGES-1:0][2:0] stage_d;

    always_comb begin
        stage_d = {stage_q[p_STAGES-2:0], d};
    end

    // Preset to 1 so a reset never manufactures a strobe edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= {p_STAGES{C_BUS_IDLE}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[p_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fsmc_slave_if.sv
// ============================================================================
//  Module   : fsmc_slave_if
//  Purpose  : FSMC async bus to register bank bridge (ren/wen pulses, read
//             data return). Optional wait output under FSMC_NWAIT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fsmc_slave_if
    import fsmc_pkg::*;
#(
    parameter int unsigned p_WIDTH_ADDR  = 16,
    parameter int unsigned p_WIDTH_DATA  = 16,
    parameter int unsigned p_SYNC_STAGES = C_SYNC_STAGES_DEFAULT
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    fsmc_bus_if.slave                    bus,
    output logic     [p_WIDTH_ADDR-1:0]  addr,
    output logic     [p_WIDTH_DATA-1:0]  wdata,
    output logic                         wen,
    output logic                         ren,
    input  wire logic [p_WIDTH_DATA-1:0] rdata
);

    logic [2:0] strobe_s;
    logic       ne_s;
    logic       noe_s;
    logic       nwe_s;
    logic       noe_fall;

    fsmc_state_t             state_q,    state_d;
    logic                    noe_prev_q, noe_prev_d;
    logic [p_WIDTH_ADDR-1:0] addr_q,     addr_d;
    logic [p_WIDTH_DATA-1:0] wdata_q,    wdata_d;
    logic [p_WIDTH_DATA-1:0] d_o_q,      d_o_d;
    logic                    d_oe_q,     d_oe_d;
    logic                    wen_q,      wen_d;
    logic                    ren_q,      ren_d;

    sync_bits #(
        .p_STAGES (p_SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.fsmc_ne, bus.fsmc_noe, bus.fsmc_nwe}),
        .q     (strobe_s)
    );

    assign ne_s     = strobe_s[2];
    assign noe_s    = strobe_s[1];
    assign nwe_s    = strobe_s[0];
    assign noe_fall = noe_prev_q & ~noe_s;

    always_comb begin
        state_d    = state_q;
        noe_prev_d = noe_s;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        d_o_d      = d_o_q;
        d_oe_d     = d_oe_q;
        wen_d      = 1'b0;
        ren_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Both strobes low is a protocol error and matches neither branch
                if (!ne_s && !nwe_s && noe_s) begin
                    state_d = ST_WR_ACT;
                    addr_d  = bus.fsmc_a;
                end else if (!ne_s && noe_fall && nwe_s) begin
                    state_d = ST_RD_REQ;
                    addr_d  = bus.fsmc_a;
                    ren_d   = 1'b1;
                end
            end
            ST_WR_ACT: begin
                if (!nwe_s) begin
                    wdata_d = bus.fsmc_d_i;
                end
                if (ne_s && !nwe_s) begin
                    state_d = ST_IDLE;
                end else if (nwe_s) begin
                    state_d = ST_IDLE;
                    wen_d   = 1'b1;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                // rdata is valid here, one cycle after the ren pulse
                d_o_d   = rdata;
                d_oe_d  = 1'b1;
                state_d = ST_RD_DRV;
            end
            ST_RD_DRV: begin
                if (noe_s || ne_s) begin
                    d_o_d   = '0;
                    d_oe_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            noe_prev_q <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            d_o_q      <= '0;
            d_oe_q     <= 1'b0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            noe_prev_q <= noe_prev_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            d_o_q      <= d_o_d;
            d_oe_q     <= d_oe_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
        end
    end

    assign addr          = addr_q;
    assign wdata         = wdata_q;
    assign wen           = wen_q;
    assign ren           = ren_q;
    assign bus.fsmc_d_o  = d_o_q;
    assign bus.fsmc_d_oe = d_oe_q;

`ifdef FSMC_NWAIT_EN
    logic nwait_q, nwait_d;

    // Low for the two cycles between the read request and the data going out
    always_comb begin
        nwait_d = !((state_d == ST_RD_REQ) || (state_d == ST_RD_CAP));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nwait_q <= 1'b1;
        end else begin
            nwait_q <= nwait_d;
        end
    end

    assign bus.fsmc_nwait = nwait_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsmc_slave_if.sv
// ============================================================================
//  Module   : tb_fsmc_slave_if
//  Purpose  : Self-checking bench for fsmc_slave_if (table, corner cases and
//             random transactions against a transaction-level memory model).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fsmc_slave_if;
    import fsmc_pkg::*;

    localparam int K_WR       = 0;
    localparam int K_WR_ABORT = 1;
    localparam int K_RD       = 2;
    localparam int K_BOTH     = 3;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] d;
        int          hold;
        logic [15:0] exp_val;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wen;
    logic        ren;
    logic [15:0] rdata = 16'h0;

    fsmc_bus_if #(.p_WIDTH_ADDR(16), .p_WIDTH_DATA(16)) bus_if ();

    fsmc_slave_if #(
        .p_WIDTH_ADDR  (16),
        .p_WIDTH_DATA  (16),
        .p_SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .addr  (addr),
        .wdata (wdata),
        .wen   (wen),
        .ren   (ren),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank stand-in: write on wen, registered read one cycle after ren
    logic [15:0] bank [65536] = '{default: 16'h0};
    always @(posedge clk) begin
        if (wen) bank[addr] <= wdata;
        if (ren) rdata <= bank[addr];
    end

    int          wen_cnt = 0;
    int          ren_cnt = 0;
    int          both_cnt = 0;
    int          oe_cnt = 0;
    int          nwait_low_cnt = 0;
    logic [15:0] wen_addr = 16'h0;
    logic [15:0] wen_data = 16'h0;
    logic [15:0] ren_addr = 16'h0;

    always @(negedge clk) begin
        if (wen === 1'b1) begin
            wen_cnt++;
            wen_addr = addr;
            wen_data = wdata;
        end
        if (ren === 1'b1) begin
            ren_cnt++;
            ren_addr = addr;
        end
        if (wen === 1'b1 && ren === 1'b1) both_cnt++;
        if (bus_if.fsmc_d_oe === 1'b1) oe_cnt++;
`ifdef FSMC_NWAIT_EN
        if (bus_if.fsmc_nwait === 1'b0) nwait_low_cnt++;
`endif
    end

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_mem [65536] = '{default: 16'h0};
    vec_t        vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete bus transaction, then checks of pulses, capture and read return
    task automatic run_txn(input int kind, input logic [15:0] a, input logic [15:0] d,
                           input int hold, input logic [15:0] exp_val, input string tag);
        int w0, r0, o0, n0;
        w0 = wen_cnt; r0 = ren_cnt; o0 = oe_cnt; n0 = nwait_low_cnt;
        bus_if.fsmc_a   = a;
        bus_if.fsmc_d_i = d;
        bus_if.fsmc_ne  = 1'b0;
        tick(); tick();
        if (kind == K_WR || kind == K_WR_ABORT) begin
            bus_if.fsmc_nwe = 1'b0;
            repeat (hold) tick();
            if (kind == K_WR_ABORT) begin
                bus_if.fsmc_ne = 1'b1;
                tick(); tick();
                bus_if.fsmc_nwe = 1'b1;
            end else begin
                bus_if.fsmc_nwe = 1'b1;
                tick(); tick();
                bus_if.fsmc_ne = 1'b1;
            end
        end else if (kind == K_RD) begin
            bus_if.fsmc_noe = 1'b0;
            repeat (4) tick();
            chk({tag, "_oe_before_latency"}, bus_if.fsmc_d_oe, 1'b0);
`ifdef FSMC_NWAIT_EN
            chk({tag, "_nwait_low"}, bus_if.fsmc_nwait, 1'b0);
`endif
            tick();
            chk({tag, "_oe_at_latency"}, bus_if.fsmc_d_oe, 1'b1);
            chk({tag, "_d_o"}, bus_if.fsmc_d_o, exp_val);
`ifdef FSMC_NWAIT_EN
            chk({tag, "_nwait_rise_with_oe"}, bus_if.fsmc_nwait, 1'b1);
`endif
            repeat (hold - 5) tick();
            bus_if.fsmc_noe = 1'b1;
            repeat (3) tick();
            chk({tag, "_oe_released"}, bus_if.fsmc_d_oe, 1'b0);
            chk({tag, "_d_o_cleared"}, bus_if.fsmc_d_o, 16'h0);
            bus_if.fsmc_ne = 1'b1;
        end else begin
            bus_if.fsmc_noe = 1'b0;
            bus_if.fsmc_nwe = 1'b0;
            repeat (hold) tick();
            bus_if.fsmc_noe = 1'b1;
            bus_if.fsmc_nwe = 1'b1;
            tick(); tick();
            bus_if.fsmc_ne = 1'b1;
        end
        repeat (5) tick();
        chk({tag, "_wen_count"}, wen_cnt - w0, (kind == K_WR) ? 1 : 0);
        chk({tag, "_ren_count"}, ren_cnt - r0, (kind == K_RD) ? 1 : 0);
        if (kind == K_WR) begin
            chk({tag, "_wen_addr"}, wen_addr, a);
            chk({tag, "_wen_data"}, wen_data, d);
            ref_mem[a] = d;
        end
        if (kind == K_RD) begin
            chk({tag, "_ren_addr"}, ren_addr, a);
`ifdef FSMC_NWAIT_EN
            chk({tag, "_nwait_cycles"}, nwait_low_cnt - n0, 2);
`endif
        end else begin
            chk({tag, "_oe_never"}, oe_cnt - o0, 0);
        end
    endtask

    initial begin
        int kind, hold;
        logic [15:0] a, d;

        vecs[0]  = '{K_WR,       16'h0002, 16'hBEEF, 8,  16'hBEEF};
        vecs[1]  = '{K_WR,       16'h0001, 16'h1234, 6,  16'h1234};
        vecs[2]  = '{K_RD,       16'h0001, 16'h0000, 8,  16'h1234};
        vecs[3]  = '{K_WR_ABORT, 16'h0003, 16'h5555, 8,  16'h0000};
        vecs[4]  = '{K_RD,       16'h0003, 16'h0000, 7,  16'h0000};
        vecs[5]  = '{K_BOTH,     16'h0005, 16'h7777, 10, 16'h0000};
        vecs[6]  = '{K_WR,       16'hFFFF, 16'hA5A5, 4,  16'hA5A5};
        vecs[7]  = '{K_RD,       16'hFFFF, 16'h0000, 6,  16'hA5A5};
        vecs[8]  = '{K_WR,       16'h0000, 16'hFFFF, 12, 16'hFFFF};
        vecs[9]  = '{K_RD,       16'h0000, 16'h0000, 9,  16'hFFFF};
        vecs[10] = '{K_RD,       16'h0002, 16'h0000, 6,  16'hBEEF};

        rst_n = 1'b0;
        bus_if.fsmc_ne  = 1'b1;
        bus_if.fsmc_noe = 1'b1;
        bus_if.fsmc_nwe = 1'b1;
        bus_if.fsmc_a   = 16'h0;
        bus_if.fsmc_d_i = 16'h0;
        repeat (3) tick();
        chk("rst_oe", bus_if.fsmc_d_oe, 1'b0);
        chk("rst_d_o", bus_if.fsmc_d_o, 16'h0);
        chk("rst_addr", addr, 16'h0);
        chk("rst_wdata", wdata, 16'h0);
        chk("rst_pulses", {wen, ren}, 2'b00);
`ifdef FSMC_NWAIT_EN
        chk("rst_nwait", bus_if.fsmc_nwait, 1'b1);
`endif
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].kind, vecs[i].a, vecs[i].d, vecs[i].hold, vecs[i].exp_val,
                    $sformatf("vec%0d", i));
        end
        chk("t3_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Reset pulse while the read data is being driven
        bus_if.fsmc_a  = 16'h0002;
        bus_if.fsmc_ne = 1'b0;
        tick(); tick();
        bus_if.fsmc_noe = 1'b0;
        repeat (6) tick();
        chk("t5_pre_oe", bus_if.fsmc_d_oe, 1'b1);
        rst_n = 1'b0;
        bus_if.fsmc_ne  = 1'b1;
        bus_if.fsmc_noe = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("t5_oe", bus_if.fsmc_d_oe, 1'b0);
        chk("t5_d_o", bus_if.fsmc_d_o, 16'h0);
        chk("t5_state", 32'(dut.state_q), 32'(ST_IDLE));
        repeat (4) tick();
        run_txn(K_WR, 16'h0004, 16'h0001, 8, 16'h0001, "t5_wr");
        run_txn(K_RD, 16'h0004, 16'h0000, 8, 16'h0001, "t5_rd");

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            kind = (kind < 4) ? K_WR : (kind < 8) ? K_RD : (kind == 8) ? K_WR_ABORT : K_BOTH;
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            d = 16'($urandom);
            hold = (kind == K_RD) ? int'($urandom_range(6, 12)) : int'($urandom_range(4, 12));
            run_txn(kind, a, d, hold, ref_mem[a], $sformatf("rnd%0d", n));
        end

        chk("never_wen_and_ren", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
